// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select feeding the register file write port.
// Holds on stall, loads a bubble on flush, suppresses writes to r0 and to reserved
// selects, flags reserved selects stickily and counts retired instructions.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_RegWrite,
    input  logic [1:0]        in_WBSel,
    input  logic [ADDR_W-1:0] in_write,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_memData,
    input  logic [DATA_W-1:0] in_pcPlus4,
    output logic [DATA_W-1:0] writeData,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retired,
    output logic              wbsel_err
);

    localparam logic [1:0] SelAlu  = 2'b00;
    localparam logic [1:0] SelMem  = 2'b01;
    localparam logic [1:0] SelLink = 2'b10;
    localparam logic [1:0] SelRsvd = 2'b11;

    logic              valid_q,     valid_d;
    logic              regwrite_q,  regwrite_d;
    logic [1:0]        wbsel_q,     wbsel_d;
    logic [ADDR_W-1:0] write_q,     write_d;
    logic [DATA_W-1:0] alu_q,       alu_d;
    logic [DATA_W-1:0] mem_q,       mem_d;
    logic [DATA_W-1:0] pc4_q,       pc4_d;
    logic [CNT_W-1:0]  retired_q,   retired_d;
    logic              wbsel_err_q, wbsel_err_d;
    logic              retire;

    // Stage register next state: flush beats stall beats load.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        wbsel_d    = wbsel_q;
        write_d    = write_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        pc4_d      = pc4_q;
        if (flush) begin
            // Only the qualifiers matter for a bubble; data fields simply hold.
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (!stall) begin
            valid_d    = in_valid;
            regwrite_d = in_RegWrite;
            wbsel_d    = in_WBSel;
            write_d    = in_write;
            alu_d      = in_aluResult;
            mem_d      = in_memData;
            pc4_d      = in_pcPlus4;
        end
    end

    // Retirement bookkeeping: the instruction in WB retires unless stalled, even when
    // a flush is replacing what comes next.
    always_comb begin
        retire      = valid_q & ~stall;
        retired_d   = retired_q + {{(CNT_W-1){1'b0}}, retire};
        wbsel_err_d = wbsel_err_q | (retire & (wbsel_q == SelRsvd));
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            wbsel_q     <= 2'b00;
            write_q     <= '0;
            alu_q       <= '0;
            mem_q       <= '0;
            pc4_q       <= '0;
            retired_q   <= '0;
            wbsel_err_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            wbsel_q     <= wbsel_d;
            write_q     <= write_d;
            alu_q       <= alu_d;
            mem_q       <= mem_d;
            pc4_q       <= pc4_d;
            retired_q   <= retired_d;
            wbsel_err_q <= wbsel_err_d;
        end
    end

    // Writeback select and register file write qualification.
    always_comb begin
        case (wbsel_q)
            SelAlu:  writeData = alu_q;
            SelMem:  writeData = mem_q;
            SelLink: writeData = pc4_q;
            default: writeData = '0;
        endcase
        // Stall gating keeps a held instruction from writing more than once.
        RegWrite  = valid_q & regwrite_q & (write_q != '0) & (wbsel_q != SelRsvd) & ~stall;
        write     = write_q;
        wb_valid  = valid_q;
        retired   = retired_q;
        wbsel_err = wbsel_err_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with literal expectations,
// a randomized phase against a slot-level reference model, and a 4-bit counter copy
// to observe wrap-around.
module tb_mem_wb_stage;

    logic        CLK;
    logic        RST;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_RegWrite;
    logic [1:0]  in_WBSel;
    logic [4:0]  in_write;
    logic [31:0] in_aluResult;
    logic [31:0] in_memData;
    logic [31:0] in_pcPlus4;

    logic [31:0] writeData;
    logic        RegWrite;
    logic [4:0]  write;
    logic        wb_valid;
    logic [31:0] retired;
    logic        wbsel_err;

    logic [31:0] writeData4;
    logic        RegWrite4;
    logic [4:0]  write4;
    logic        wb_valid4;
    logic [3:0]  retired4;
    logic        wbsel_err4;

    int unsigned errors;
    int unsigned checks;

    // Reference model: contents of the WB slot plus architectural counters.
    logic        m_valid;
    logic        m_rw;
    logic [1:0]  m_sel;
    logic [4:0]  m_idx;
    logic [31:0] m_alu;
    logic [31:0] m_mem;
    logic [31:0] m_pc4;
    int unsigned m_retired;
    logic        m_err;

    mem_wb_stage dut (
        .CLK          (CLK),
        .RST          (RST),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_RegWrite  (in_RegWrite),
        .in_WBSel     (in_WBSel),
        .in_write     (in_write),
        .in_aluResult (in_aluResult),
        .in_memData   (in_memData),
        .in_pcPlus4   (in_pcPlus4),
        .writeData    (writeData),
        .RegWrite     (RegWrite),
        .write        (write),
        .wb_valid     (wb_valid),
        .retired      (retired),
        .wbsel_err    (wbsel_err)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .CLK          (CLK),
        .RST          (RST),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_RegWrite  (in_RegWrite),
        .in_WBSel     (in_WBSel),
        .in_write     (in_write),
        .in_aluResult (in_aluResult),
        .in_memData   (in_memData),
        .in_pcPlus4   (in_pcPlus4),
        .writeData    (writeData4),
        .RegWrite     (RegWrite4),
        .write        (write4),
        .wb_valid     (wb_valid4),
        .retired      (retired4),
        .wbsel_err    (wbsel_err4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data();
        case (m_sel)
            2'd0:    return m_alu;
            2'd1:    return m_mem;
            2'd2:    return m_pc4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_we();
        return m_valid && m_rw && (m_idx != 5'd0) && (m_sel != 2'd3) && !stall;
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_rw      = 1'b0;
        m_sel     = 2'd0;
        m_idx     = 5'd0;
        m_alu     = 32'd0;
        m_mem     = 32'd0;
        m_pc4     = 32'd0;
        m_retired = 0;
        m_err     = 1'b0;
    endtask

    // Model of one rising edge using the inputs present at that edge.
    task automatic model_edge();
        if (RST) begin
            model_reset();
        end else begin
            if (m_valid && !stall) begin
                m_retired++;
                if (m_sel == 2'd3) m_err = 1'b1;
            end
            if (flush) begin
                m_valid = 1'b0;
                m_rw    = 1'b0;
            end else if (!stall) begin
                m_valid = in_valid;
                m_rw    = in_RegWrite;
                m_sel   = in_WBSel;
                m_idx   = in_write;
                m_alu   = in_aluResult;
                m_mem   = in_memData;
                m_pc4   = in_pcPlus4;
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model, mid-cycle.
    task automatic compare_all();
        chk("writeData", writeData, exp_data());
        chk("RegWrite",  RegWrite,  exp_we());
        chk("write",     write,     m_idx);
        chk("wb_valid",  wb_valid,  m_valid);
        chk("retired",   retired,   m_retired);
        chk("wbsel_err", wbsel_err, m_err);
        chk("writeData4", writeData4, exp_data());
        chk("RegWrite4",  RegWrite4,  exp_we());
        chk("write4",     write4,     m_idx);
        chk("wb_valid4",  wb_valid4,  m_valid);
        chk("retired4",   retired4,   m_retired % 16);
        chk("wbsel_err4", wbsel_err4, m_err);
    endtask

    task automatic half_a();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic half_b();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [4:0] idx, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4);
        in_valid     = v;
        in_RegWrite  = rw;
        in_WBSel     = sel;
        in_write     = idx;
        in_aluResult = alu;
        in_memData   = mem;
        in_pcPlus4   = pc4;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_writeData"}, writeData, 32'd0);
        chk({tag, "_RegWrite"},  RegWrite,  1'b0);
        chk({tag, "_write"},     write,     5'd0);
        chk({tag, "_wb_valid"},  wb_valid,  1'b0);
        chk({tag, "_retired"},   retired,   32'd0);
        chk({tag, "_wbsel_err"}, wbsel_err, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_reset();

        // Reset with busy inputs: outputs must be zero without any clock edge.
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 2'd1, 5'd7, 32'hAAAA5555, 32'h12345678, 32'h100);
        RST = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();

        // ALU result to r5.
        drive(1'b1, 1'b1, 2'd0, 5'd5, 32'h1234, 32'hFFFF, 32'h8);
        cycle();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        half_a();
        chk("alu_we",   RegWrite,  1'b1);
        chk("alu_idx",  write,     5'd5);
        chk("alu_data", writeData, 32'h00001234);
        half_b();
        half_a();
        chk("alu_retired", retired, 32'd1);
        half_b();

        // Load then link on consecutive cycles.
        drive(1'b1, 1'b1, 2'd1, 5'd8, 32'h1, 32'hDEADBEEF, 32'h2);
        cycle();
        drive(1'b1, 1'b1, 2'd2, 5'd31, 32'h3, 32'h4, 32'h40);
        half_a();
        chk("load_data", writeData, 32'hDEADBEEF);
        chk("load_we",   RegWrite,  1'b1);
        half_b();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        half_a();
        chk("link_data", writeData, 32'h40);
        chk("link_we",   RegWrite,  1'b1);
        chk("link_idx",  write,     5'd31);
        half_b();

        // r0 destination retires but never writes.
        drive(1'b1, 1'b1, 2'd0, 5'd0, 32'h7, 32'd0, 32'd0);
        cycle();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        half_a();
        chk("r0_we", RegWrite, 1'b0);
        half_b();
        half_a();
        chk("r0_retired", retired, 32'd4);
        half_b();

        // Three stalled cycles, then a single write on release.
        drive(1'b1, 1'b1, 2'd0, 5'd9, 32'h99, 32'd0, 32'd0);
        cycle();
        stall = 1'b1;
        repeat (3) begin
            half_a();
            chk("stall_we",      RegWrite, 1'b0);
            chk("stall_retired", retired,  32'd4);
            chk("stall_idx",     write,    5'd9);
            half_b();
        end
        stall = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        half_a();
        chk("release_we",  RegWrite, 1'b1);
        chk("release_idx", write,    5'd9);
        half_b();
        half_a();
        chk("release_retired", retired, 32'd5);
        chk("release_we_once", RegWrite, 1'b0);
        half_b();

        // Flush wins over stall.
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 1'b1, 2'd0, 5'd12, 32'h55, 32'd0, 32'd0);
        cycle();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        half_a();
        chk("flush_valid",   wb_valid, 1'b0);
        chk("flush_we",      RegWrite, 1'b0);
        chk("flush_retired", retired,  32'd5);
        half_b();

        // Reserved select: no write, sticky error, still retires.
        drive(1'b1, 1'b1, 2'd3, 5'd3, 32'h11, 32'h22, 32'h33);
        cycle();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        half_a();
        chk("rsvd_data", writeData, 32'd0);
        chk("rsvd_we",   RegWrite,  1'b0);
        chk("rsvd_err_before", wbsel_err, 1'b0);
        half_b();
        half_a();
        chk("rsvd_err",     wbsel_err, 1'b1);
        chk("rsvd_retired", retired,   32'd6);
        half_b();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom, $urandom, $urandom);
            cycle();
        end

        // Asynchronous reset asserted while stalling and flushing.
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 1'b1, 2'd2, 5'd17, 32'h1, 32'h2, 32'h3);
        #2;
        RST = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        cycle();
        RST   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 5'd4, 32'hCAFE, 32'd0, 32'd0);
        cycle();
        half_a();
        chk("post_reset_valid", wb_valid,  1'b1);
        chk("post_reset_data",  writeData, 32'hCAFE);
        half_b();

        // Counter wrap: 16 retirements on the 4-bit copy.
        RST = 1'b1;
        #1;
        model_reset();
        cycle();
        RST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 2'd0, 5'(i + 1), 32'(i), 32'd0, 32'd0);
            cycle();
        end
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        half_a();
        chk("wrap_retired4", retired4, 4'd0);
        chk("wrap_retired",  retired,  32'd16);
        half_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
